multi_data_bank: RTL
====================

MULTI_DATA_BANK -- requirements
Module: multi_data_bank

Interface
REQ-001 Parameter DATA_W, default 12, word width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W words per bank.
REQ-003 Parameter NUM_BANKS, default 4, number of independent banks.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with these ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  synchronous reset, active-high.
- SEN  in  1  store-path enable.
- SWEN  in  NUM_BANKS  store-path write enable, one bit per bank.
- SREN  in  NUM_BANKS  store-path read enable, one bit per bank.
- IEN  in  1  intermediate-path enable.
- IWEN  in  NUM_BANKS  intermediate-path write enable, one bit per bank.
- IREN  in  NUM_BANKS  intermediate-path read enable, one bit per bank.
- A1  in  NUM_BANKS*ADDR_W  write addresses; bank b uses slice b.
- A2  in  NUM_BANKS*ADDR_W  read addresses; bank b uses slice b.
- D  in  NUM_BANKS*DATA_W  write data; bank b uses slice b.
- CLR  in  1  pulse that requests a full memory clear.
- Q  out  NUM_BANKS*DATA_W  registered read data.
- RVALID  out  NUM_BANKS  high for one cycle when the matching Q slice was updated by a read.
- INIT_BUSY  out  1  high while a clear sweep runs.
- ERR  out  1  sticky flag; set when SEN and IEN are both high in READY.

Function
REQ-005 Path select in READY: IEN=1 selects the I path (IWEN/IREN); otherwise SEN=1 selects the S path (SWEN/SREN); otherwise there is no access.
REQ-006 Effective write for bank b: selected WEN[b]=1 SHALL write D slice b to bank b at A1 slice b at the clock edge.
REQ-007 Effective read for bank b: selected REN[b]=1 SHALL load Q slice b with bank b at A2 slice b. Latency is 1 cycle. RVALID[b]=1 in that same cycle.
REQ-008 When no read is issued to bank b, Q slice b SHALL hold its value and RVALID[b]=0.
REQ-009 Banks SHALL be fully independent. Any mix of reads and writes across banks is legal in one cycle.
REQ-010 FSM states: CLEAR and READY.
- CLEAR: address counter cnt writes 0 to address cnt in every bank each cycle; INIT_BUSY=1; all user enables are ignored; RVALID=0.
- When cnt = DEPTH-1, the FSM SHALL move to READY on the next edge and cnt SHALL wrap to 0.
- READY: CLR=1 SHALL move the FSM to CLEAR with cnt=0.
- CLR during CLEAR SHALL be ignored; the sweep is not restarted.
REQ-011 A clear sweep SHALL take exactly DEPTH cycles. INIT_BUSY SHALL fall on the edge where the state becomes READY.
REQ-012 ERR SHALL be set when SEN=1 and IEN=1 in READY. It is cleared only by rst. The I path still wins.
REQ-013 A clear sweep SHALL leave Q unchanged.

Reset
REQ-014 rst=1 SHALL force: Q=0, RVALID=0, ERR=0, state=CLEAR, cnt=0, INIT_BUSY=1.
REQ-015 rst asserted mid-sweep SHALL restart the sweep at address 0.
REQ-016 Memory arrays have no reset port. The post-reset sweep SHALL initialise them.

Configuration
REQ-017 Macro MDB_BYPASS_EN controls same-cycle read and write to the same bank and address.
- Defined: Q SHALL return the new D (write-first).
- Undefined: Q SHALL return the previous stored word (read-first). This is the block-RAM-inferable form.

Structure
REQ-018 Package mdb_pkg SHALL hold the FSM state enum (CLEAR, READY) and the default values of DATA_W, ADDR_W and NUM_BANKS.
REQ-019 Sub-module bank_ram SHALL implement one DATA_W x DEPTH bank with a write port and a registered read port. It SHALL carry the ram_style "block" attribute and honour MDB_BYPASS_EN. The top SHALL instantiate it NUM_BANKS times.
REQ-020 The FSM, path muxing and ERR logic SHALL reside in the top module.

Verification
REQ-021 Release rst. INIT_BUSY SHALL stay high for exactly 32 cycles (defaults), then fall. A read of bank 2, addr 7 SHALL then return 0 with RVALID[2]=1 one cycle later.
REQ-022 SEN=1, SWEN=4'b0001, A1 slice 0 = 3, D slice 0 = 12'hABC. Next cycle SREN[0]=1, A2 slice 0 = 3. Q slice 0 SHALL equal 12'hABC one cycle later, with RVALID=4'b0001.
REQ-023 SEN=1 and IEN=1 together; IWEN[1]=1 writes 12'h111; SWEN[1]=1 writes 12'h222 to the same address. A read SHALL return 12'h111, and ERR SHALL be 1 and remain 1.
REQ-024 Same-cycle write of 12'h5A5 over 12'h0F0 at bank 0, addr 9, with a read of the same location. Q SHALL be 12'h5A5 with MDB_BYPASS_EN and 12'h0F0 without it.
REQ-025 Write 12'hFFF to bank 3, addr 31. Pulse CLR; pulse CLR again 5 cycles later. INIT_BUSY SHALL stay high for 32 cycles from the first CLR. Bank 3, addr 31 SHALL then read 0.
REQ-026 Assert rst at sweep cycle 20. The sweep SHALL restart and INIT_BUSY SHALL stay high for 32 more cycles. All banks SHALL read 0 at addresses 0-31.

Source files
------------

// File: rtl/mdb_pkg.sv
// rtl/mdb_pkg.sv - shared types and default sizes for the multi-bank memory
//
// Contents:
//   DEF_DATA_W, DEF_ADDR_W, DEF_NUM_BANKS  default parameter values
//   state_t                                 controller state (CLEAR, READY)
package mdb_pkg;

    localparam int DEF_DATA_W    = 12;
    localparam int DEF_ADDR_W    = 5;
    localparam int DEF_NUM_BANKS = 4;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

// File: rtl/bank_ram.sv
// rtl/bank_ram.sv - one DATA_W x 2**ADDR_W bank, write port plus registered read port
//
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset (clears the read register only)
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable; rdata updates only when set
//   raddr  in   read address
//   rdata  out  registered read data
//
// Build option: MDB_BYPASS_EN selects write-first on a same-address
// read/write collision; without it the bank is read-first.
module bank_ram
    import mdb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    // Array has no reset; the controller's clear sweep initialises it.
    (* ram_style = "block" *) logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
`ifdef MDB_BYPASS_EN
            if (we && (waddr == raddr)) begin
                rdata <= wdata;
            end else begin
                rdata <= mem[raddr];
            end
`else
            rdata <= mem[raddr];
`endif
        end
    end

endmodule

// File: rtl/multi_data_bank.sv
// rtl/multi_data_bank.sv - NUM_BANKS independent memory banks with dual access paths and clear sweep
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   SEN, SWEN, SREN    store-path enable and per-bank write/read enables
//   IEN, IWEN, IREN    intermediate-path enable and per-bank write/read enables
//   A1, A2             per-bank write / read addresses (bank b uses slice b)
//   D                  per-bank write data
//   CLR                request a full memory clear (ignored while clearing)
//   Q                  per-bank registered read data
//   RVALID             per-bank one-cycle read strobe, aligned with Q
//   INIT_BUSY          high while the clear sweep runs
//   ERR                sticky: SEN and IEN seen together while READY
//
// Build option: MDB_BYPASS_EN (write-first collisions, see bank_ram).
module multi_data_bank
    import mdb_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int NUM_BANKS = DEF_NUM_BANKS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        SEN,
    input  logic [NUM_BANKS-1:0]        SWEN,
    input  logic [NUM_BANKS-1:0]        SREN,
    input  logic                        IEN,
    input  logic [NUM_BANKS-1:0]        IWEN,
    input  logic [NUM_BANKS-1:0]        IREN,
    input  logic [NUM_BANKS*ADDR_W-1:0] A1,
    input  logic [NUM_BANKS*ADDR_W-1:0] A2,
    input  logic [NUM_BANKS*DATA_W-1:0] D,
    input  logic                        CLR,
    output logic [NUM_BANKS*DATA_W-1:0] Q,
    output logic [NUM_BANKS-1:0]        RVALID,
    output logic                        INIT_BUSY,
    output logic                        ERR
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic [NUM_BANKS-1:0] wen_sel;
    logic [NUM_BANKS-1:0] ren_sel;
    logic [NUM_BANKS-1:0] bank_we;
    logic [NUM_BANKS-1:0] bank_re;

    // The I path has priority; user enables only matter while READY.
    always_comb begin
        wen_sel = '0;
        ren_sel = '0;
        if (state == READY) begin
            if (IEN) begin
                wen_sel = IWEN;
                ren_sel = IREN;
            end else if (SEN) begin
                wen_sel = SWEN;
                ren_sel = SREN;
            end
        end
        // During the sweep every bank writes zero at cnt; no reads, so Q holds.
        if (rst) begin
            bank_we = '0;
            bank_re = '0;
        end else if (state == CLEAR) begin
            bank_we = '1;
            bank_re = '0;
        end else begin
            bank_we = wen_sel;
            bank_re = ren_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            cnt       <= '0;
            INIT_BUSY <= 1'b1;
            ERR       <= 1'b0;
            RVALID    <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    RVALID <= '0;
                    if (cnt == LAST_ADDR) begin
                        state     <= READY;
                        cnt       <= '0;
                        INIT_BUSY <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READY: begin
                    RVALID <= ren_sel;
                    if (SEN && IEN) begin
                        ERR <= 1'b1;
                    end
                    if (CLR) begin
                        state     <= CLEAR;
                        cnt       <= '0;
                        INIT_BUSY <= 1'b1;
                    end
                end
                default: begin
                    state     <= CLEAR;
                    cnt       <= '0;
                    INIT_BUSY <= 1'b1;
                end
            endcase
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;

        assign waddr = (state == CLEAR) ? cnt : A1[b*ADDR_W +: ADDR_W];
        assign wdata = (state == CLEAR) ? '0  : D[b*DATA_W +: DATA_W];

        bank_ram #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_ram (
            .clk   (clk),
            .rst   (rst),
            .we    (bank_we[b]),
            .waddr (waddr),
            .wdata (wdata),
            .re    (bank_re[b]),
            .raddr (A2[b*ADDR_W +: ADDR_W]),
            .rdata (Q[b*DATA_W +: DATA_W])
        );
    end

endmodule
